// File: rtl/tx_serializer.sv
// Byte-stream 8N1 UART transmitter with an internal FIFO that absorbs bursts from a
// producer that cannot be stalled; bytes arriving while the FIFO is full are dropped and flagged.
module tx_serializer #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] sdata,
  input  logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned BaudW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 overflow_q, overflow_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [FIFO_AW-1:0]   wptr_q, wptr_d;
  logic [FIFO_AW-1:0]   rptr_q, rptr_d;
  logic [7:0]           mem_q [Depth];

  logic push;
  logic pop;
  logic baud_end;
  logic fifo_nonempty;

  assign push          = tx_ready && (count_q != FullCount);
  assign baud_end      = (baud_q == BaudLast);
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rptr_d     = rptr_q;
    pop        = 1'b0;
    baud_d     = (state_q == StIdle || baud_end) ? '0 : baud_q + 1'b1;
    overflow_d = overflow_q | (tx_ready & ~push);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;

    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        // Chain straight into the next start bit so back-to-back frames have no idle gap.
        if (baud_end) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      shift_d = mem_q[rptr_q];
      rptr_d  = rptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= sdata;
    end
  end

  assign txd      = txd_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle) | fifo_nonempty;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: frame-level reference model checked every cycle, a segment table
// for the single-byte waveform, and a line decoder for multi-frame sequences.
module tb_tx_serializer;

  localparam int unsigned Cpb      = 4;
  localparam int unsigned FifoAw   = 4;
  localparam int unsigned Depth    = 16;
  localparam int unsigned FrameLen = 10 * Cpb;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       tx_ready = 1'b0;
  logic [7:0] sdata = 8'h00;
  logic       txd;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  tx_serializer #(
    .CLK_PER_BIT(Cpb),
    .FIFO_AW    (FifoAw)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sdata   (sdata),
    .tx_ready(tx_ready),
    .txd     (txd),
    .busy    (busy),
    .overflow(overflow)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: pending bytes, the byte on the wire, and cycles elapsed in its frame.
  logic [7:0]  m_q[$];
  logic [7:0]  m_cur;
  bit          m_active;
  int unsigned m_t;
  bit          m_ovf;

  logic        rec = 1'b0;
  logic        cap_q[$];
  logic [7:0]  dec_q[$];
  logic [7:0]  sent_q[$];

  typedef struct {
    int unsigned first;
    int unsigned last;
    logic        txd;
    logic        busy;
  } seg_t;

  seg_t tab[8];

  function automatic void model_reset();
    m_q.delete();
    m_cur    = 8'h00;
    m_active = 1'b0;
    m_t      = 0;
    m_ovf    = 1'b0;
  endfunction

  function automatic void model_step();
    bit ended, do_pop, take;
    if (!rstn) begin
      model_reset();
      return;
    end
    ended  = m_active && (m_t == FrameLen - 1);
    do_pop = (m_q.size() != 0) && (!m_active || ended);
    take   = tx_ready && (m_q.size() < Depth);
    if (tx_ready && !take) m_ovf = 1'b1;
    if (do_pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else if (ended) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
    end
    if (take) m_q.push_back(sdata);
  endfunction

  function automatic logic model_txd();
    int unsigned b;
    if (!m_active) return 1'b1;
    b = m_t / Cpb;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (rec) cap_q.push_back(txd);
    check("model txd", {31'd0, txd}, {31'd0, model_txd()});
    check("model busy", {31'd0, busy}, {31'd0, (m_active || m_q.size() != 0)});
    check("model overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic strobe(input logic [7:0] b);
    sdata    = b;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, input string name,
                           output int unsigned n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic decode();
    int unsigned i;
    logic [7:0] b;
    dec_q.delete();
    i = 0;
    while (i + FrameLen <= cap_q.size()) begin
      if (cap_q[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = cap_q[i + Cpb / 2 + Cpb * (k + 1)];
        dec_q.push_back(b);
        i += FrameLen;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    int unsigned n;
    logic [7:0] b;

    tab[0] = '{0, 0, 1'b1, 1'b1};
    tab[1] = '{1, 4, 1'b0, 1'b1};
    tab[2] = '{5, 8, 1'b1, 1'b1};
    tab[3] = '{9, 28, 1'b0, 1'b1};
    tab[4] = '{29, 32, 1'b1, 1'b1};
    tab[5] = '{33, 36, 1'b0, 1'b1};
    tab[6] = '{37, 40, 1'b1, 1'b1};
    tab[7] = '{41, 45, 1'b1, 1'b0};

    model_reset();

    // Reset held for three cycles with strobes toggling.
    #2 rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdata    = 8'hC3;
      tx_ready = ~tx_ready;
      tick();
      check("reset txd", {31'd0, txd}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset overflow", {31'd0, overflow}, 32'd0);
    end
    tx_ready = 1'b0;
    rstn     = 1'b1;
    cap_q.delete();
    rec = 1'b1;
    repeat (60) tick();
    decode();
    check("no frame after reset", dec_q.size(), 32'd0);

    // Single byte 0x41 against the segment table.
    strobe(8'h41);
    for (int s = 0; s < 8; s++) begin
      for (int o = tab[s].first; o <= tab[s].last; o++) begin
        if (o != 0) tick();
        check("single txd", {31'd0, txd}, {31'd0, tab[s].txd});
        check("single busy", {31'd0, busy}, {31'd0, tab[s].busy});
      end
    end

    // Back-to-back frames.
    cap_q.delete();
    strobe(8'h00);
    strobe(8'hFF);
    strobe(8'h55);
    wait_idle(300, "b2b busy timeout", n);
    check("b2b length", n, 32'd119);
    decode();
    check("b2b count", dec_q.size(), 32'd3);
    if (dec_q.size() == 3) begin
      check("b2b byte0", {24'd0, dec_q[0]}, 32'h00);
      check("b2b byte1", {24'd0, dec_q[1]}, 32'hFF);
      check("b2b byte2", {24'd0, dec_q[2]}, 32'h55);
    end

    // Overflow: 18 consecutive strobes, the last one is dropped.
    cap_q.delete();
    for (int i = 0; i < 18; i++) begin
      strobe(8'(i));
      check("overflow edge", {31'd0, overflow}, (i == 17) ? 32'd1 : 32'd0);
    end
    wait_idle(17 * FrameLen + 50, "overflow busy timeout", n);
    decode();
    check("overflow count", dec_q.size(), 32'd17);
    for (int i = 0; i < 17 && i < dec_q.size(); i++) begin
      check("overflow byte", {24'd0, dec_q[i]}, i);
    end
    check("overflow sticky", {31'd0, overflow}, 32'd1);

    // Reset during data bit 3 of the first frame.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    strobe(8'hA5);
    strobe(8'h3C);
    repeat (17) tick();
    check("pre-reset txd bit3", {31'd0, txd}, 32'd0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("async reset txd", {31'd0, txd}, 32'd1);
    check("async reset busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    cap_q.delete();
    repeat (100) tick();
    decode();
    check("no frame after mid reset", dec_q.size(), 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd0);

    // Pointer wrap: 40 bytes with gaps that keep the FIFO from filling.
    cap_q.delete();
    sent_q.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      sent_q.push_back(b);
      strobe(b);
      repeat ($urandom_range(35, 45)) tick();
    end
    wait_idle(20 * FrameLen, "wrap busy timeout", n);
    decode();
    check("wrap count", dec_q.size(), 32'd40);
    for (int i = 0; i < 40 && i < dec_q.size(); i++) begin
      check("wrap byte", {24'd0, dec_q[i]}, {24'd0, sent_q[i]});
    end
    check("wrap overflow", {31'd0, overflow}, 32'd0);

    // Random traffic, light then heavy, against the model.
    rec = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      sdata    = 8'($urandom);
      tx_ready = ($urandom_range(0, 99) < ((i < 1800) ? 4 : 60));
      tick();
    end
    tx_ready = 1'b0;
    wait_idle(20 * FrameLen, "random busy timeout", n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
